// File: rtl/grid_ccff_loader.sv
// Parallel configuration-chain loader: serial bits shift into NUM_CHAINS chains and are
// committed to a shadow register on completion. Define GRID_CCFF_PARITY_EN for a per-chain even-parity check.
module grid_ccff_loader #(
    parameter int NUM_CHAINS = 2,
    parameter int CHAIN_LEN  = 20
) (
    input  logic                            prog_clk,
    input  logic                            pReset,
    input  logic [NUM_CHAINS-1:0]           ccff_head,
    input  logic                            ccff_en,
    input  logic                            cfg_clear,
    output logic [NUM_CHAINS-1:0]           ccff_tail,
    output logic [NUM_CHAINS*CHAIN_LEN-1:0] cfg_bits,
    output logic                            cfg_busy,
    output logic                            cfg_done,
    output logic                            cfg_err
);
    localparam int CW = $clog2(CHAIN_LEN + 1);
    localparam logic [CW-1:0] LAST = CW'(CHAIN_LEN);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] SHIFT = 3'd1;
    localparam logic [2:0] DONE  = 3'd3;
`ifdef GRID_CCFF_PARITY_EN
    localparam logic [2:0] PARITY = 3'd2;
    localparam logic [2:0] ERR    = 3'd4;
`endif

    logic [2:0]                       state_q, state_d;
    logic [CW-1:0]                    cnt_q, cnt_d;
    logic [NUM_CHAINS*CHAIN_LEN-1:0]  sr_q, sr_shift;
    logic [NUM_CHAINS*CHAIN_LEN-1:0]  bits_q, bits_d;
    logic                             shift_en;

    // All chains live in one flat vector laid out exactly like cfg_bits, so a commit is a plain copy.
    always_comb begin
        sr_shift  = '0;
        ccff_tail = '0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            sr_shift[c*CHAIN_LEN +: CHAIN_LEN] = {sr_q[c*CHAIN_LEN +: CHAIN_LEN-1], ccff_head[c]};
            ccff_tail[c] = sr_q[c*CHAIN_LEN + CHAIN_LEN - 1];
        end
    end

`ifdef GRID_CCFF_PARITY_EN
    logic par_bad;

    always_comb begin
        par_bad = 1'b0;
        for (int c = 0; c < NUM_CHAINS; c++) begin
            par_bad = par_bad | ((^sr_q[c*CHAIN_LEN +: CHAIN_LEN]) ^ ccff_head[c]);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bits_d   = bits_q;
        shift_en = 1'b0;
        if (cfg_clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, SHIFT: begin
                    if (ccff_en) begin
                        shift_en = 1'b1;
                        cnt_d    = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
                        state_d  = SHIFT;
                        if (cnt_d == LAST) begin
`ifdef GRID_CCFF_PARITY_EN
                            state_d = PARITY;
`else
                            state_d = DONE;
                            bits_d  = sr_shift;
`endif
                        end
                    end
                end
`ifdef GRID_CCFF_PARITY_EN
                // The parity bit is only inspected, never shifted into the chains.
                PARITY: begin
                    if (ccff_en) begin
                        if (par_bad) begin
                            state_d = ERR;
                        end else begin
                            state_d = DONE;
                            bits_d  = sr_q;
                        end
                    end
                end
                ERR: state_d = ERR;
`endif
                DONE: state_d = DONE;
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bits_q  <= bits_d;
            if (shift_en) begin
                sr_q <= sr_shift;
            end
        end
    end

    assign cfg_bits = bits_q;
    assign cfg_done = (state_q == DONE);
`ifdef GRID_CCFF_PARITY_EN
    assign cfg_busy = (state_q == SHIFT) || (state_q == PARITY);
    assign cfg_err  = (state_q == ERR);
`else
    assign cfg_busy = (state_q == SHIFT);
    assign cfg_err  = 1'b0;
`endif

endmodule

// File: tb/tb_grid_ccff_loader.sv
// Scoreboarded bench for grid_ccff_loader (2 chains x 4 bits); follows GRID_CCFF_PARITY_EN if defined.
module tb_grid_ccff_loader;
    localparam int NC = 2;
    localparam int L  = 4;
`ifdef GRID_CCFF_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic         prog_clk = 1'b0;
    logic         pReset;
    logic [NC-1:0] ccff_head;
    logic         ccff_en;
    logic         cfg_clear;
    logic [NC-1:0] ccff_tail;
    logic [NC*L-1:0] cfg_bits;
    logic         cfg_busy;
    logic         cfg_done;
    logic         cfg_err;

    grid_ccff_loader #(.NUM_CHAINS(NC), .CHAIN_LEN(L)) dut (
        .prog_clk  (prog_clk),
        .pReset    (pReset),
        .ccff_head (ccff_head),
        .ccff_en   (ccff_en),
        .cfg_clear (cfg_clear),
        .ccff_tail (ccff_tail),
        .cfg_bits  (cfg_bits),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    always #5 prog_clk = ~prog_clk;

    typedef enum int {M_IDLE, M_LOAD, M_PAR, M_DONE, M_ERR} phase_t;
    typedef struct packed {
        logic          done;
        logic          err;
        logic [NC*L-1:0] bits;
    } exp_t;

    // Reference model: history of every bit pair shifted in since reset, plus the load phase.
    phase_t      phase;
    int          accepted;
    logic [1:0]  hist[$];
    logic [7:0]  committed;
    exp_t        sbq[$];
    int          checks;
    int          errors;
    logic        evtPrev;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic logic [7:0] lastBits();
        logic [7:0] v;
        int n;
        v = '0;
        n = hist.size();
        for (int c = 0; c < NC; c++) begin
            for (int i = 0; i < L; i++) begin
                int idx;
                idx = n - L + i;
                if (idx >= 0) v[c*L + L-1-i] = hist[idx][c];
            end
        end
        return v;
    endfunction

    function automatic logic [1:0] expTail();
        int n;
        n = hist.size();
        return (n >= L) ? hist[n-L] : 2'b00;
    endfunction

    function automatic bit parityOk(input logic [1:0] p);
        logic [7:0] v;
        v = lastBits();
        for (int c = 0; c < NC; c++) begin
            if ((($countones(v[c*L +: L]) + int'(p[c])) % 2) != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic modelReset();
        phase = M_IDLE;
        accepted = 0;
        hist.delete();
        committed = '0;
    endtask

    task automatic modelEdge(input logic [1:0] head, input logic en, input logic clr);
        if (clr) begin
            phase = M_IDLE;
            accepted = 0;
        end else if ((phase == M_IDLE || phase == M_LOAD) && en) begin
            hist.push_back(head);
            if (hist.size() > 16) void'(hist.pop_front());
            accepted++;
            if (accepted == L) begin
                if (PAR) begin
                    phase = M_PAR;
                end else begin
                    phase = M_DONE;
                    committed = lastBits();
                    sbq.push_back('{done: 1'b1, err: 1'b0, bits: committed});
                end
            end else begin
                phase = M_LOAD;
            end
        end else if (phase == M_PAR && en) begin
            if (parityOk(head)) begin
                phase = M_DONE;
                committed = lastBits();
                sbq.push_back('{done: 1'b1, err: 1'b0, bits: committed});
            end else begin
                phase = M_ERR;
                sbq.push_back('{done: 1'b0, err: 1'b1, bits: committed});
            end
        end
    endtask

    task automatic checkAll();
        checkOutput("busy", 32'(cfg_busy), 32'(phase == M_LOAD || phase == M_PAR));
        checkOutput("done", 32'(cfg_done), 32'(phase == M_DONE));
        checkOutput("err", 32'(cfg_err), 32'(phase == M_ERR));
        checkOutput("bits", 32'(cfg_bits), 32'(committed));
        checkOutput("tail", 32'(ccff_tail), 32'(expTail()));
    endtask

    task automatic applyStimulus(input logic [1:0] head, input logic en, input logic clr);
        ccff_head = head;
        ccff_en   = en;
        cfg_clear = clr;
        @(posedge prog_clk);
        modelEdge(head, en, clr);
        #1;
        checkAll();
    endtask

    // Monitor: each new done/err indication consumes one expected completion.
    always @(negedge prog_clk) begin
        exp_t e;
        if (!pReset) begin
            evtPrev <= 1'b0;
        end else begin
            if ((cfg_done || cfg_err) && !evtPrev) begin
                if (sbq.size() == 0) begin
                    checkOutput("sb_unexpected_completion", 32'(1), 32'(0));
                end else begin
                    e = sbq.pop_front();
                    checkOutput("sb_done", 32'(cfg_done), 32'(e.done));
                    checkOutput("sb_err", 32'(cfg_err), 32'(e.err));
                    checkOutput("sb_bits", 32'(cfg_bits), 32'(e.bits));
                end
            end
            evtPrev <= cfg_done || cfg_err;
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        evtPrev = 1'b0;
        modelReset();
        pReset = 1'b0;
        ccff_head = '0;
        ccff_en = 1'b0;
        cfg_clear = 1'b0;
        #2;
        checkAll();
        repeat (2) @(posedge prog_clk);
        #1 pReset = 1'b1;
        #1 checkAll();

        // First load from reset: chain0 = 1010, chain1 = 0110.
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("busy_mid_load", 32'(cfg_busy), 32'(1));
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("tail_first_bit", 32'(ccff_tail[0]), 32'(1));
`ifdef GRID_CCFF_PARITY_EN
        applyStimulus(2'b00, 1'b1, 1'b0);
`endif
        checkOutput("load_done", 32'(cfg_done), 32'(1));
        checkOutput("load_bits", 32'(cfg_bits), 32'h6A);

`ifdef GRID_CCFF_PARITY_EN
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0);
        checkOutput("parity_err", 32'(cfg_err), 32'(1));
        checkOutput("err_keeps_bits", 32'(cfg_bits), 32'h6A);
        applyStimulus(2'b11, 1'b1, 1'b0);
        checkOutput("err_holds", 32'(cfg_err), 32'(1));
`endif

        // Clear wins over a simultaneous strobe.
        applyStimulus(2'b11, 1'b1, 1'b1);
        checkOutput("clear_busy", 32'(cfg_busy), 32'(0));
        checkOutput("clear_done", 32'(cfg_done), 32'(0));
        checkOutput("clear_bits", 32'(cfg_bits), 32'h6A);
        checkOutput("clear_no_shift", 32'(ccff_tail), 32'h1);

        // Reload with new data: chain0 = 1101, chain1 = 1100.
        applyStimulus(2'b11, 1'b1, 1'b0);
        applyStimulus(2'b11, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        checkOutput("reload_bits_held", 32'(cfg_bits), 32'h6A);
        applyStimulus(2'b01, 1'b1, 1'b0);
`ifdef GRID_CCFF_PARITY_EN
        applyStimulus(2'b01, 1'b1, 1'b0);
`endif
        checkOutput("reload_bits", 32'(cfg_bits), 32'hCD);

        // Gapped load of the first pattern.
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            applyStimulus(2'(g), 1'b0, 1'b0);
            checkOutput("gap_busy", 32'(cfg_busy), 32'(1));
        end
        applyStimulus(2'b11, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
`ifdef GRID_CCFF_PARITY_EN
        applyStimulus(2'b00, 1'b1, 1'b0);
`endif
        checkOutput("gap_bits", 32'(cfg_bits), 32'h6A);
        checkOutput("gap_done", 32'(cfg_done), 32'(1));

        // Abort mid-load keeps the committed value.
        applyStimulus(2'b00, 1'b0, 1'b1);
        applyStimulus(2'b11, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b1);
        checkOutput("abort_bits", 32'(cfg_bits), 32'h6A);

        // Asynchronous reset mid-load, observed before any further clock edge.
        applyStimulus(2'b01, 1'b1, 1'b0);
        applyStimulus(2'b10, 1'b1, 1'b0);
        #2 pReset = 1'b0;
        #1;
        modelReset();
        checkOutput("async_reset_busy", 32'(cfg_busy), 32'(0));
        checkOutput("async_reset_bits", 32'(cfg_bits), 32'(0));
        checkOutput("async_reset_tail", 32'(ccff_tail), 32'(0));
        checkAll();
        ccff_en = 1'b0;
        @(posedge prog_clk);
        #1 pReset = 1'b1;
        #1 checkAll();

        for (int i = 0; i < 400; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0), ($urandom_range(0, 11) == 0));
        end

        applyStimulus(2'b00, 1'b0, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b0);
        checkOutput("sb_drained", 32'(sbq.size()), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/grid_ccff_loader.md
GRID_CCFF_LOADER -- requirements
Module: grid_ccff_loader

Interface
REQ-001 SHALL have parameter NUM_CHAINS, default 2: number of parallel configuration chains.
REQ-002 SHALL have parameter CHAIN_LEN, default 20: data bits per chain, legal range 2..256.
REQ-003 SHALL have port prog_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port pReset, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port ccff_head, input, NUM_CHAINS: serial config bit, one per chain.
REQ-006 SHALL have port ccff_en, input, 1: bit-valid strobe; one bit per chain is consumed per cycle when high.
REQ-007 SHALL have port cfg_clear, input, 1: synchronous abort/restart.
REQ-008 SHALL have port ccff_tail, output, NUM_CHAINS: MSB of each chain shift register, combinational.
REQ-009 SHALL have port cfg_bits, output, NUM_CHAINS*CHAIN_LEN: committed configuration; chain c occupies bits [c*CHAIN_LEN +: CHAIN_LEN].
REQ-010 SHALL have port cfg_busy, output, 1: high in SHIFT or PARITY.
REQ-011 SHALL have port cfg_done, output, 1: high in DONE.
REQ-012 SHALL have port cfg_err, output, 1: high in ERR.

Function
REQ-013 SHALL implement FSM states IDLE, SHIFT, PARITY, DONE, ERR, plus a bit counter of width clog2(CHAIN_LEN+1).
REQ-014 Shift rule SHALL be: on each accepted bit, sr[c] <= {sr[c][CHAIN_LEN-2:0], ccff_head[c]} for every chain, and the counter increments.
REQ-015 IDLE with ccff_en=1 SHALL accept that bit, set counter=1, go SHIFT; with ccff_en=0 it SHALL stay in IDLE.
REQ-016 SHIFT with ccff_en=0 SHALL stall (no shift, no count); gaps of any length are legal.
REQ-017 When the accepted bit makes counter==CHAIN_LEN, the FSM SHALL leave SHIFT on that edge (to PARITY or DONE per REQ-026/027).
REQ-018 Entering DONE SHALL copy all sr[c] into the cfg_bits shadow register in the same edge; cfg_done asserts the following cycle.
REQ-019 DONE and ERR SHALL ignore ccff_en (no shift) and hold until cfg_clear or reset.
REQ-020 cfg_clear=1 in any state SHALL go IDLE and zero the counter without changing sr or cfg_bits; cfg_clear takes priority over a simultaneous ccff_en.
REQ-021 An abort (cfg_clear) in SHIFT/PARITY SHALL leave the previously committed cfg_bits unchanged (double-buffered reload).
REQ-022 Exactly one of IDLE/busy/done/err conditions SHALL be indicated; cfg_busy, cfg_done, and cfg_err are never high together.
REQ-023 Total load latency SHALL be CHAIN_LEN (+1 with parity) accepted bits, plus 1 cycle to cfg_done.

Reset
REQ-024 pReset low SHALL asynchronously force IDLE, counter=0, all sr=0, cfg_bits=0.
REQ-025 All outputs SHALL read 0 during and immediately after reset (ccff_tail=0, busy=done=err=0); reset mid-load discards the partial load.

Configuration
REQ-026 With macro GRID_CCFF_PARITY_EN defined, SHIFT SHALL go to PARITY after bit CHAIN_LEN; the next accepted bit per chain is a parity bit (not shifted); even parity over data+parity must be 0 on every chain -> DONE with commit, else ERR without commit.
REQ-027 Without GRID_CCFF_PARITY_EN, the PARITY state and cfg_err logic SHALL be absent, SHIFT goes directly to DONE, and cfg_err is tied 0.

Verification
REQ-028 Bench SHALL cover, with NUM_CHAINS=2 and CHAIN_LEN=4 (bits listed first-to-last, {chain1,chain0} per cycle):
- Parity off: load {0,1},{1,0},{1,1},{0,0} -> cfg_bits=8'b0110_1010, cfg_done=1 one cycle after 4th bit.
- ccff_en low for 3 cycles between bits 2 and 3 -> identical result; cfg_busy high throughout.
- Parity on: same data plus parity {0,0} -> DONE, commit; parity {1,0} -> ERR, cfg_bits retains prior value.
- After DONE, cfg_clear together with ccff_en=1 -> IDLE, no shift, cfg_bits unchanged; then reload overwrites cfg_bits only at new DONE.
- pReset low asserted mid-SHIFT (after bit 2) -> immediate IDLE, all outputs 0, without waiting for prog_clk.
- ccff_tail equals bit shifted in CHAIN_LEN accepted cycles earlier (chain0 first bit 1 -> ccff_tail[0]=1 after 4th shift).
